// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one combinational ALU between two
// requesters, with per-op multicycle hold and early rejection of bad ops.
module alu_arbiter #(
  parameter int BASE_LAT = 1,
  parameter int MUL_LAT  = 2,
  parameter int DIV_LAT  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_op1,
  input  logic [31:0] req0_op2,
  input  logic [3:0]  req0_sel,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_op1,
  input  logic [31:0] req1_op2,
  input  logic [3:0]  req1_sel,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_data,
  output logic        rsp0_zf,
  output logic        rsp0_err,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_data,
  output logic        rsp1_zf,
  output logic        rsp1_err,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic [3:0]  alu_sel,
  input  logic [31:0] alu_out,
  input  logic        alu_zf
);

  localparam int MAXL_A = (BASE_LAT > MUL_LAT) ? BASE_LAT : MUL_LAT;
  localparam int MAXL   = (MAXL_A > DIV_LAT) ? MAXL_A : DIV_LAT;
  localparam int CW     = (MAXL > 1) ? $clog2(MAXL) : 1;

  localparam logic [CW-1:0] BL_M1 = CW'(BASE_LAT - 1);
  localparam logic [CW-1:0] ML_M1 = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DL_M1 = CW'(DIV_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t        state;
  logic          last_grant;
  logic          owner;
  logic [CW-1:0] cnt;
  logic [31:0]   data;
  logic          zf;
  logic          err;

  logic          gnt0;
  logic          gnt1;
  logic          acc;
  logic          acc_id;
  logic [31:0]   a_op1;
  logic [31:0]   a_op2;
  logic [3:0]    a_sel;
  logic          legal;
  logic          bad;
  logic [CW-1:0] lat_m1;
  logic          rsp_hs;

  // requester 0 wins a tie unless it was the last one served
  always_comb begin
    gnt0 = req0_valid && (!req1_valid || last_grant);
    gnt1 = req1_valid && (!req0_valid || !last_grant);
  end

  assign req0_ready = rst_n && (state == IDLE) && gnt0;
  assign req1_ready = rst_n && (state == IDLE) && gnt1;

  assign acc    = req0_ready || req1_ready;
  assign acc_id = req1_ready;
  assign a_op1  = acc_id ? req1_op1 : req0_op1;
  assign a_op2  = acc_id ? req1_op2 : req0_op2;
  assign a_sel  = acc_id ? req1_sel : req0_sel;

  always_comb begin
    legal  = 1'b1;
    lat_m1 = BL_M1;
    case (a_sel)
      4'b0000, 4'b0001, 4'b0010,
      4'b0110, 4'b0111: lat_m1 = BL_M1;
      4'b0101:          lat_m1 = ML_M1;
      4'b1111:          lat_m1 = DL_M1;
      default: begin
        legal  = 1'b0;
        lat_m1 = '0;
      end
    endcase
  end

  assign bad = !legal || ((a_sel == 4'b1111) && (a_op2 == 32'd0));

  assign rsp_hs = (rsp0_valid && rsp0_ready) ||
                  (rsp1_valid && rsp1_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      cnt        <= '0;
      data       <= '0;
      zf         <= 1'b0;
      err        <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      alu_op1    <= '0;
      alu_op2    <= '0;
      alu_sel    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (acc) begin
            owner      <= acc_id;
            last_grant <= acc_id;
            if (bad) begin
              data       <= '0;
              zf         <= 1'b0;
              err        <= 1'b1;
              rsp0_valid <= !acc_id;
              rsp1_valid <= acc_id;
              state      <= RESP;
            end else begin
              alu_op1 <= a_op1;
              alu_op2 <= a_op2;
              alu_sel <= a_sel;
              cnt     <= lat_m1;
              state   <= EXEC;
            end
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            data       <= alu_out;
            zf         <= alu_zf;
            err        <= 1'b0;
            rsp0_valid <= !owner;
            rsp1_valid <= owner;
            state      <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_hs) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp0_data = data;
  assign rsp0_zf   = zf;
  assign rsp0_err  = err;
  assign rsp1_data = data;
  assign rsp1_zf   = zf;
  assign rsp1_err  = err;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench with a reference ALU, directed and
// randomized traffic on both requesters.
module tb_alu_arbiter;

  localparam int BL = 1;
  localparam int ML = 2;
  localparam int DL = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  rv, rdy, rsv, rr, rz, re;
  logic [31:0] ra [2];
  logic [31:0] rb [2];
  logic [3:0]  rs [2];
  logic [31:0] rd [2];
  logic [31:0] alu_op1, alu_op2, alu_out;
  logic [3:0]  alu_sel;
  logic        alu_zf;

  alu_arbiter #(.BASE_LAT(BL), .MUL_LAT(ML), .DIV_LAT(DL)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(rv[0]), .req0_ready(rdy[0]),
    .req0_op1(ra[0]), .req0_op2(rb[0]), .req0_sel(rs[0]),
    .req1_valid(rv[1]), .req1_ready(rdy[1]),
    .req1_op1(ra[1]), .req1_op2(rb[1]), .req1_sel(rs[1]),
    .rsp0_valid(rsv[0]), .rsp0_ready(rr[0]),
    .rsp0_data(rd[0]), .rsp0_zf(rz[0]), .rsp0_err(re[0]),
    .rsp1_valid(rsv[1]), .rsp1_ready(rr[1]),
    .rsp1_data(rd[1]), .rsp1_zf(rz[1]), .rsp1_err(re[1]),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_zf(alu_zf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int asserts = 0;
  int fails = 0;

  function automatic void check(string name, logic [31:0] act,
                                logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endfunction

  function automatic void check_b(string name, logic act, logic exp);
    check(name, {31'b0, act}, {31'b0, exp});
  endfunction

  function automatic logic [31:0] alu_f(logic [31:0] a, logic [31:0] b,
                                        logic [3:0] s);
    logic [31:0] y;
    case (s)
      4'd0:    y = a & b;
      4'd1:    y = a | b;
      4'd2:    y = a + b;
      4'd6:    y = a - b;
      4'd7:    y = (a < b) ? 32'd1 : 32'd0;
      4'd5:    y = a * b;
      4'd15:   y = (b == 0) ? 32'hffff_ffff : a / b;
      default: y = 32'd0;
    endcase
    return y;
  endfunction

  always_comb begin
    alu_out = alu_f(alu_op1, alu_op2, alu_sel);
    alu_zf  = (alu_out == 32'd0);
  end

  typedef struct {
    logic [31:0] d;
    logic        z;
    logic        e;
    int          due;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  s;
    bit          w;
  } stim_t;

  exp_t  eq0 [$];
  exp_t  eq1 [$];
  stim_t sq0 [$];
  stim_t sq1 [$];

  function automatic void model(logic [31:0] a, logic [31:0] b,
                                logic [3:0] s, int t,
                                output exp_t x, output int lat);
    if (s inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd7}) lat = BL;
    else if (s == 4'd5) lat = ML;
    else if (s == 4'd15) lat = DL;
    else lat = 0;
    if (lat == 0 || (s == 4'd15 && b == 0)) begin
      x.d = 32'd0; x.z = 1'b0; x.e = 1'b1; x.due = t + 1;
      lat = 0;
    end else begin
      x.d = alu_f(a, b, s); x.z = (x.d == 0); x.e = 1'b0;
      x.due = t + lat + 1;
    end
  endfunction

  // scoreboard monitor
  bit          tb_busy = 1'b0;
  bit          tb_last = 1'b1;
  bit [1:0]    seen = 2'b00;
  int          ex_from = -1;
  int          ex_to = -2;
  logic [31:0] ex_a, ex_b;
  logic [3:0]  ex_s;

  always @(negedge clk) begin
    exp_t x;
    int   lat;
    if (rst_n) begin
      check_b("ready_onehot", rdy == 2'b11, 1'b0);
      for (int r = 0; r < 2; r++) begin
        if (rv[r] && rdy[r]) begin
          check_b("accept_while_busy", tb_busy, 1'b0);
          if (rv == 2'b11) check_b("rr_grant", r[0], ~tb_last);
          model(ra[r], rb[r], rs[r], cyc, x, lat);
          if (r == 0) eq0.push_back(x);
          else eq1.push_back(x);
          tb_busy = 1'b1;
          tb_last = r[0];
          if (!x.e) begin
            ex_from = cyc + 1; ex_to = cyc + lat;
            ex_a = ra[r]; ex_b = rb[r]; ex_s = rs[r];
          end
        end
      end
      if (cyc >= ex_from && cyc <= ex_to) begin
        check("alu_op1_hold", alu_op1, ex_a);
        check("alu_op2_hold", alu_op2, ex_b);
        check("alu_sel_hold", {28'b0, alu_sel}, {28'b0, ex_s});
      end
      check_b("alu_sel_legal",
              alu_sel inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd5, 4'd15},
              1'b1);
      check_b("alu_div0", alu_sel == 4'd15 && alu_op2 == 0, 1'b0);
      check_b("rsp_onehot", rsv == 2'b11, 1'b0);
      for (int r = 0; r < 2; r++) begin
        if (rsv[r]) begin
          int n;
          n = (r == 0) ? eq0.size() : eq1.size();
          check("rsp_expected", n, 1);
          if (n > 0) begin
            x = (r == 0) ? eq0[0] : eq1[0];
            if (!seen[r]) check("rsp_latency", cyc, x.due);
            seen[r] = 1'b1;
            check("rsp_data", rd[r], x.d);
            check_b("rsp_zf", rz[r], x.z);
            check_b("rsp_err", re[r], x.e);
            if (rr[r]) begin
              if (r == 0) void'(eq0.pop_front());
              else void'(eq1.pop_front());
              seen[r] = 1'b0;
              tb_busy = 1'b0;
            end
          end
        end
      end
    end
  end

  // requester drivers
  logic [1:0] dbusy = 2'b00;
  logic [1:0] wd = 2'b00;
  logic [1:0] acc_l = 2'b00;
  int         rhold [2] = '{0, 0};
  bit         rrand = 1'b0;

  initial begin
    stim_t st;
    rv = 2'b00; rr = 2'b11;
    for (int r = 0; r < 2; r++) begin
      ra[r] = '0; rb[r] = '0; rs[r] = '0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int r = 0; r < 2; r++) begin
        if (!rst_n) begin
          dbusy[r] = 1'b0;
        end else begin
          if (dbusy[r] && (acc_l[r] || wd[r])) dbusy[r] = 1'b0;
          if (!dbusy[r] && ((r == 0) ? sq0.size() : sq1.size()) > 0) begin
            st = (r == 0) ? sq0.pop_front() : sq1.pop_front();
            ra[r] = st.a; rb[r] = st.b; rs[r] = st.s; wd[r] = st.w;
            dbusy[r] = 1'b1;
          end
        end
        rv[r] = dbusy[r];
        if (rhold[r] > 0) rr[r] = 1'b0;
        else if (rrand) rr[r] = 1'($urandom_range(0, 1));
        else rr[r] = 1'b1;
      end
      @(negedge clk);
      for (int r = 0; r < 2; r++) begin
        acc_l[r] = rv[r] & rdy[r];
        if (rsv[r] && rhold[r] > 0) rhold[r]--;
      end
    end
  end

  task automatic push(input int r, input logic [31:0] a,
                      input logic [31:0] b, input logic [3:0] s,
                      input bit w);
    stim_t st;
    st.a = a; st.b = b; st.s = s; st.w = w;
    if (r == 0) sq0.push_back(st);
    else sq1.push_back(st);
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while ((sq0.size() > 0 || sq1.size() > 0 || dbusy != 2'b00 ||
            eq0.size() > 0 || eq1.size() > 0) && n < maxc) begin
      @(posedge clk);
      n++;
    end
    check_b("drain_timeout", n >= maxc, 1'b0);
    repeat (2) @(posedge clk);
  endtask

  task automatic check_reset(string tag);
    check({tag, "_req_ready"}, {30'b0, rdy}, 32'd0);
    check({tag, "_rsp_valid"}, {30'b0, rsv}, 32'd0);
    check({tag, "_rsp0_data"}, rd[0], 32'd0);
    check({tag, "_rsp1_data"}, rd[1], 32'd0);
    check({tag, "_rsp_zf"}, {30'b0, rz}, 32'd0);
    check({tag, "_rsp_err"}, {30'b0, re}, 32'd0);
    check({tag, "_alu_op1"}, alu_op1, 32'd0);
    check({tag, "_alu_op2"}, alu_op2, 32'd0);
    check({tag, "_alu_sel"}, {28'b0, alu_sel}, 32'd0);
  endtask

  task automatic wait_acc1(input int maxc);
    int n = 0;
    while (eq1.size() == 0 && n < maxc) begin
      @(posedge clk);
      n++;
    end
    check_b("accept_timeout", n >= maxc, 1'b0);
  endtask

  logic [3:0] lg [7] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd5, 4'd15};

  initial begin
    repeat (3) @(posedge clk);
    #2;
    check_reset("por");
    rst_n = 1'b1;

    for (int i = 0; i < 2; i++) begin
      push(0, 32'd9, 32'd9, 4'd6, 1'b0);
      push(1, 32'd9, 32'd9, 4'd6, 1'b0);
    end
    drain(200);

    push(0, 32'd5, 32'd7, 4'd2, 1'b0);
    drain(100);

    rhold[1] = 3;
    push(1, 32'd100, 32'd7, 4'd15, 1'b0);
    wait_acc1(50);
    push(0, 32'hf0f0, 32'h0ff0, 4'd0, 1'b0);
    drain(200);

    push(0, 32'd5, 32'd0, 4'd15, 1'b0);
    push(0, 32'd5, 32'd3, 4'd3, 1'b0);
    drain(100);

    push(0, 32'h1_0000, 32'h1_0000, 4'd5, 1'b0);
    push(1, 32'd3, 32'd8, 4'd7, 1'b0);
    drain(100);

    rrand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, b;
      logic [3:0]  s;
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      s = ($urandom_range(0, 3) != 0) ? lg[$urandom_range(0, 6)]
                                      : 4'($urandom_range(0, 15));
      push($urandom_range(0, 1), a, b, s, $urandom_range(0, 7) == 0);
    end
    drain(20000);
    rrand = 1'b0;

    push(1, 32'd100, 32'd7, 4'd15, 1'b0);
    wait_acc1(50);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset("mid_exec");
    eq0.delete(); eq1.delete();
    tb_busy = 1'b0; tb_last = 1'b1; seen = 2'b00;
    ex_from = -1; ex_to = -2;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    push(0, 32'd1, 32'd2, 4'd2, 1'b0);
    push(1, 32'd3, 32'd4, 4'd2, 1'b0);
    drain(100);
    repeat (10) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts, fails);
    $finish;
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 32-bit combinational ALU between two requesters.
- Arbitration is round-robin. Each request goes through a valid/ready handshake; each response has its own valid/ready handshake.
- The block holds the ALU operands stable for a per-operation latency (MUL/DIV get multicycle paths), then registers the result and zero flag.
- It rejects illegal selects and divide-by-zero without issuing them to the ALU.

Parameters:
- BASE_LAT, 1, EXEC cycles for AND/OR/ADD/SUB/SLT (min 1)
- MUL_LAT, 2, EXEC cycles for MUL (min 1)
- DIV_LAT, 4, EXEC cycles for DIV (min 1)

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid / req1_valid  in  1  requester 0/1 has an operation
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_op1, req0_op2 / req1_op1, req1_op2  in  32  operands
- req0_sel / req1_sel  in  4  ALU select code
- rsp0_valid / rsp1_valid  out  1  response available
- rsp0_ready / rsp1_ready  in  1  requester takes response
- rsp0_data / rsp1_data  out  32  result
- rsp0_zf / rsp1_zf  out  1  zero flag
- rsp0_err / rsp1_err  out  1  illegal select or divide-by-zero
- alu_op1, alu_op2  out  32  to ALU
- alu_sel  out  4  to ALU
- alu_out  in  32  from ALU
- alu_zf  in  1  from ALU

Behaviour:
- Legal selects:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT: BASE_LAT.
  - 0101 MUL: MUL_LAT.
  - 1111 DIV: DIV_LAT.
  - Every other code is illegal.
- FSM states are IDLE, EXEC and RESP.
- Reset (async, any state):
  - state=IDLE, last_grant=1 (requester 0 wins first tie).
  - All req*_ready=0, all rsp*_valid=0.
  - All rsp*_data=0, rsp*_zf=0, rsp*_err=0.
  - alu_op1=alu_op2=0, alu_sel=0000.
- IDLE grant:
  - Only one req valid: grant it.
  - Both valid: grant the requester that is not last_grant.
  - req*_ready is combinational and high only in IDLE, only for the granted requester, and only if its req_valid is high.
  - Never both ready in one cycle.
- On accept (cycle T): latch op1/op2/sel/owner, update last_grant=owner.
  - Legal sel and no div-by-zero: go to EXEC with cnt=lat-1.
  - Illegal sel, or DIV with op2==0: go directly to RESP with data=0, zf=0, err=1. The ALU is not driven with that request.
- EXEC:
  - alu_op1/op2/sel come from the latched registers and stay stable for the whole of EXEC.
  - cnt decrements each cycle.
  - At cnt==0: register alu_out to data and alu_zf to zf, set err=0, go to RESP.
- Latency:
  - Legal op accepted at T gives rsp_valid at T+lat+1.
  - Error case gives rsp_valid at T+1.
- RESP:
  - Only the owner's rsp_valid is high.
  - data/zf/err are held stable until rsp_ready.
  - Handshake cycle goes to IDLE.
  - A new request can be accepted the cycle after the response handshake, so there is one bubble. The block is not pipelined.
- Outside RESP:
  - Non-owner rsp_valid=0; rsp_data/zf/err are undefined.
  - Outside EXEC, alu_* hold their last values.
- Requests arriving while busy see ready=0 and must be held by the requester. A request withdrawn before accept is never executed.
- SLT is unsigned, per the ALU. Results are the ALU's 32-bit truncation; the block does no width extension.
- Simultaneous reset and handshake: reset wins; the response is lost.

Test Plan:
- req0 ADD 5+7 alone -> accepted at T; rsp0_valid at T+2 with data=12, zf=0, err=0; rsp1_valid stays 0.
- req0 and req1 both valid from reset, both SUB 9-9 -> req0 granted first, rsp0 data=0 zf=1. Then req1 granted, with a one-cycle IDLE bubble after the rsp0 handshake. Back-to-back ties alternate 0,1,0,1.
- req1 DIV 100/7 with DIV_LAT=4 -> alu_sel=1111 and operands stable for 4 cycles; rsp1 data=14 at T+5. Holding rsp1_ready=0 for 3 cycles keeps data stable and blocks req0.
- req0 DIV op2=0, then req0 sel=0011 -> each response comes at T+1 with err=1, data=0, zf=0; alu_sel never shows these requests.
- MUL 0x10000*0x10000 -> data=0 (truncated), zf=1, at T+3 with MUL_LAT=2.
- rst_n asserted mid-EXEC of a DIV -> outputs go to reset values immediately; after release, req0 wins the first tie and the aborted op produces no response.
